johnson_seq_ctrl: RTL and testbench

JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

---
 rtl/johnson_seq_ctrl.sv | 103 ++++++++++
 tb/tb_johnson_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/johnson_seq_ctrl.sv
// Johnson sequence controller.
// Runs a 4-bit Johnson counter for a requested number of full 8-state rounds,
// with pause, abort, a one-cycle completion pulse and a sticky illegal-state flag.
module johnson_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] num_rounds,
    input  logic       pause,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [3:0] count,
    output logic [7:0] phase,
    output logic [7:0] round_cnt,
    output logic       err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [7:0] rounds_lat;
    logic [3:0] next_count;
    logic [7:0] next_round;
    logic       legal;

    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign next_count = {~count[0], count[3:1]};
    assign next_round = round_cnt + 8'd1;
    assign legal      = (phase != 8'h00);

    // One-hot position of count within the Johnson ring; zero flags an illegal code
    always_comb begin
        phase = 8'h00;
        case (count)
            4'b0000: phase = 8'h01;
            4'b1000: phase = 8'h02;
            4'b1100: phase = 8'h04;
            4'b1110: phase = 8'h08;
            4'b1111: phase = 8'h10;
            4'b0111: phase = 8'h20;
            4'b0011: phase = 8'h40;
            4'b0001: phase = 8'h80;
            default: phase = 8'h00;
        endcase
    end

    // Sequencer: illegal-code recovery outranks everything but reset, then abort, pause, stepping
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'b0000;
            round_cnt  <= 8'd0;
            rounds_lat <= 8'd0;
            err        <= 1'b0;
        end else if (!legal) begin
            err   <= 1'b1;
            count <= 4'b0000;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (num_rounds != 8'd0) begin
                            state      <= RUN;
                            rounds_lat <= num_rounds;
                            round_cnt  <= 8'd0;
                            count      <= 4'b0000;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        count     <= 4'b0000;
                        round_cnt <= 8'd0;
                    end else if (!pause) begin
                        count <= next_count;
                        if (count == 4'b0001) begin
                            round_cnt <= next_round;
                            if (next_round == rounds_lat) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed testbench for johnson_seq_ctrl with hand-computed expectations.
module tb_johnson_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] num_rounds;
    logic       pause;
    logic       abort;
    logic       busy;
    logic       done;
    logic [3:0] count;
    logic [7:0] phase;
    logic [7:0] round_cnt;
    logic       err;

    int total;
    int bad;
    int busyCycles;
    logic [3:0] seq [8];
    logic [7:0] expPhase;

    johnson_seq_ctrl dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_rounds(num_rounds),
        .pause(pause),
        .abort(abort),
        .busy(busy),
        .done(done),
        .count(count),
        .phase(phase),
        .round_cnt(round_cnt),
        .err(err)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic rst, input logic st, input logic [7:0] nr,
                                 input logic pa, input logic ab);
        reset      = rst;
        start      = st;
        num_rounds = nr;
        pause      = pa;
        abort      = ab;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // One rising edge, then settle on the falling edge for sampling and driving
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkIdleReset(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_count"}, count, 0);
        checkOutput({tag, "_round"}, round_cnt, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_phase"}, phase, 8'h01);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        seq[0] = 4'b0000; seq[1] = 4'b1000; seq[2] = 4'b1100; seq[3] = 4'b1110;
        seq[4] = 4'b1111; seq[5] = 4'b0111; seq[6] = 4'b0011; seq[7] = 4'b0001;

        // Reset for two cycles
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        tick();
        tick();
        checkIdleReset("reset");

        // Two rounds; num_rounds input changes after acceptance, stray start mid-run
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd5, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            expPhase = 8'h01 << (i % 8);
            checkOutput("run2_busy", busy, 1);
            checkOutput("run2_count", count, seq[i % 8]);
            checkOutput("run2_phase", phase, expPhase);
            checkOutput("run2_round", round_cnt, i / 8);
            start = (i == 3);
            tick();
        end
        start = 1'b0;
        checkOutput("run2_done", done, 1);
        checkOutput("run2_busy_end", busy, 0);
        checkOutput("run2_count_end", count, 0);
        checkOutput("run2_round_end", round_cnt, 2);
        tick();
        checkOutput("run2_done_clear", done, 0);
        checkOutput("run2_round_hold", round_cnt, 2);
        checkOutput("run2_idle", busy, 0);

        // One round with a three-cycle pause at 1110
        applyStimulus(1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        busyCycles = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            busyCycles += busy ? 1 : 0;
        end
        checkOutput("pause_at", count, 4'b1110);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("pause_hold", count, 4'b1110);
            busyCycles += busy ? 1 : 0;
        end
        pause = 1'b0;
        for (int i = 0; i < 20 && busy; i++) begin
            tick();
            busyCycles += busy ? 1 : 0;
        end
        checkOutput("pause_busy_len", busyCycles, 11);
        checkOutput("pause_done", done, 1);
        checkOutput("pause_round", round_cnt, 1);
        checkOutput("pause_count", count, 0);
        tick();
        checkOutput("pause_done_once", done, 0);

        // Three rounds, abort (with pause) at 0111 in round 2, then immediate restart
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        checkOutput("abort_at_count", count, 4'b0111);
        checkOutput("abort_at_round", round_cnt, 1);
        applyStimulus(1'b0, 1'b0, 8'd3, 1'b1, 1'b1);
        tick();
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_count", count, 0);
        checkOutput("abort_round", round_cnt, 0);
        applyStimulus(1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        checkOutput("restart_busy", busy, 1);
        checkOutput("restart_count", count, 0);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("restart_done", done, 1);
        tick();

        // Zero rounds goes straight to DONE
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        checkOutput("zero_done", done, 1);
        checkOutput("zero_busy", busy, 0);
        checkOutput("zero_count", count, 0);
        tick();
        checkOutput("zero_done_clear", done, 0);
        checkOutput("zero_busy_after", busy, 0);
        checkOutput("zero_count_after", count, 0);

        // Illegal count injected during RUN
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("illegal_pre", count, 4'b1100);
        force dut.count = 4'b0101;
        tick();
        release dut.count;
        checkOutput("illegal_err", err, 1);
        checkOutput("illegal_busy", busy, 0);
        checkOutput("illegal_done", done, 0);
        tick();
        checkOutput("illegal_count", count, 0);
        checkOutput("illegal_phase", phase, 8'h01);
        checkOutput("illegal_err_sticky", err, 1);
        checkOutput("illegal_idle", busy, 0);
        applyStimulus(1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        checkOutput("err_cleared", err, 0);
        checkOutput("err_restart_busy", busy, 1);

        // Reset mid-run together with start
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
        tick();
        checkIdleReset("midreset");
        applyStimulus(1'b0, 1'b0, 8'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("post_reset_done", done, 0);
            checkOutput("post_reset_busy", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
